uart_tx_frame_sequencer: RTL and testbench
==========================================

# uart_tx_frame_sequencer

Sequences multi-byte frames through the existing UART transmitter. It accepts a wide data block, typically a 128-bit AES ciphertext, over a valid/ready handshake. It then feeds a header byte, the data bytes and an optional checksum byte to `UART_tx` one at a time, using that module's `tx_start` / `d_in` / `tx_done_flag` handshake. It sits between the AES core output and the UART transmitter in the communication module.

## Interface
Parameters:
- `NUM_BYTES`, default 16: data bytes per frame; legal range 1..32.
- `HEADER_BYTE`, default 8'hA5: first byte of every frame.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, same clock as `UART_tx`.
- `reset`  in  1  asynchronous, active-low reset.
- `block_valid`  in  1  producer has a block to send.
- `block_data`  in  8*NUM_BYTES  block payload; byte 0 = `block_data[8*NUM_BYTES-1 -: 8]` (MSB byte first).
- `block_ready`  out  1  sequencer can accept a block.
- `tx_done_flag`  in  1  one-cycle pulse from `UART_tx`, marks end of stop bit.
- `tx_start`  out  1  one-cycle pulse that starts a byte in `UART_tx`.
- `d_out`  out  8  byte to transmit; drives `UART_tx.d_in`.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame completes.

## Operation
- States: IDLE, ISSUE, WAIT, GAP, and DONE.
- **IDLE**
  - `block_ready`=1 and `busy`=0.
  - A clock edge with `block_valid`=1 captures `block_data` into a shift register, clears the byte counter and moves to ISSUE.
- **ISSUE**
  - `d_out` = current byte; `tx_start`=1 for exactly this cycle.
  - Next state is WAIT.
- **WAIT**
  - Holds `d_out` stable and waits for `tx_done_flag`=1.
  - On the pulse: if more bytes remain, increment the counter and go to GAP; otherwise go to DONE.
- **GAP**
  - One idle cycle, so that `UART_tx` has returned to its idle state before the next `tx_start`.
  - Next state is ISSUE.
- **DONE**
  - `frame_done`=1 for one cycle, then return to IDLE.
- Byte order:
  - Without the checksum feature: `HEADER_BYTE`, data bytes 0..NUM_BYTES-1.
  - With it: `HEADER_BYTE`, data bytes 0..NUM_BYTES-1, checksum byte.
- Byte counter:
  - Unsigned, width `$clog2(NUM_BYTES+2)`.
  - Counts from 0 up to the index of the last byte and never wraps.
- Outputs are registered.

## Timing
- Reset values: `block_ready`=1, `busy`=0, `tx_start`=0, `d_out`=8'h00, `frame_done`=0.
- Block acceptance → first `tx_start`: 1 cycle, since ISSUE is entered on the accepting edge.
- `tx_done_flag` → next `tx_start`: 2 cycles (WAIT→GAP→ISSUE).
- Last `tx_done_flag` → `frame_done`: 1 cycle. `block_ready` returns to 1 on the following cycle.
- `block_ready` is 0 from the acceptance edge until IDLE is re-entered. `block_valid` during that time is ignored; the producer holds it.
- `tx_done_flag` outside WAIT is ignored.
- Changes to `block_data` after acceptance have no effect.
- Asserting `reset` mid-frame:
  - Immediately forces all outputs to their reset values and the state to IDLE.
  - The frame is abandoned; nothing is resent.
- No timeout: WAIT holds indefinitely if `tx_done_flag` never arrives.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined:
  - Frame length is NUM_BYTES+2.
  - The last byte is the XOR of `HEADER_BYTE` and all data bytes.
  - The checksum accumulator clears on block acceptance and updates as each byte is issued.
- Not defined:
  - Frame length is NUM_BYTES+1.
  - No accumulator logic is present.

## Structure
- Shared package `uart_ctrl_pkg`:
  - State encoding (IDLE=0, ISSUE=1, WAIT=2, GAP=3, DONE=4).
  - Default header constant `UART_HEADER_DEFAULT`=8'hA5.
- One sub-module, `uart_frame_checksum`:
  - Byte-wide XOR accumulator with clear and enable inputs.
  - Instantiated only under `UART_FRAME_CHECKSUM_EN`.

## Test plan
- Reset release, no stimulus:
  - `block_ready`=1 and `tx_start` stays 0 for 100 cycles.
- Accept block 128'h00112233445566778899AABBCCDDEEFF, with the transmitter model returning `tx_done_flag` 20 cycles after each `tx_start`:
  - Without the checksum feature: `d_out` sequence A5,00,11,…,FF (17 `tx_start` pulses), then `frame_done`.
  - With it: 18 pulses, last byte = A5 (XOR of A5 and the 16 data bytes, which XOR to 00).
- `tx_done_flag` → next `tx_start` spacing:
  - Spacing is exactly 2 cycles every time.
  - `d_out` never changes between a `tx_start` and its `tx_done_flag`.
- `block_valid` held high with new data during a frame:
  - Second block accepted only after `frame_done`; both frames transmitted intact, back to back.
- Spurious `tx_done_flag` in IDLE and in GAP:
  - No state change, no extra byte.
- `reset` asserted after the 5th byte's `tx_start`:
  - Outputs return to reset values within the same cycle.
  - The next accepted block restarts with A5.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control path: frame sequencer state
// encoding and the default frame header byte.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] UART_HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_checksum.sv
// Byte-wide XOR accumulator. clr has priority over en; used by the frame
// sequencer to build the trailing checksum byte.
module uart_frame_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] d_in,
    output logic [7:0] acc
);

    // Accumulate XOR of every enabled byte since the last clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (en) begin
            acc <= acc ^ d_in;
        end
    end

endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// Frame sequencer between the AES output and UART_tx. Sends a header byte,
// NUM_BYTES data bytes (MSB byte first) and, when UART_FRAME_CHECKSUM_EN is
// defined, a trailing XOR checksum byte.
//
// Block handshake: a block transfers on a rising clk edge where
// block_valid && block_ready. block_ready is high only in IDLE; the producer
// holds block_valid/block_data until the transfer, and block_data is captured
// on that edge so later changes have no effect.
module uart_tx_frame_sequencer
    import uart_ctrl_pkg::*;
#(
    parameter int         NUM_BYTES   = 16,
    parameter logic [7:0] HEADER_BYTE = UART_HEADER_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   block_valid,
    input  logic [8*NUM_BYTES-1:0] block_data,
    output logic                   block_ready,
    input  logic                   tx_done_flag,
    output logic                   tx_start,
    output logic [7:0]             d_out,
    output logic                   busy,
    output logic                   frame_done,
    output state_t                 state_dbg
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES + 2);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int LAST  = NUM_BYTES + 1;
    localparam logic [CNT_W-1:0] DATA_LAST_IDX = CNT_W'(NUM_BYTES);
`else
    localparam int LAST  = NUM_BYTES;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DW-1:0]     shreg, shreg_n;
    logic [7:0]        d_out_n;
    logic              tx_start_n, frame_done_n, block_ready_n, busy_n;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] csum;

    // Clear on acceptance; fold in each non-checksum byte while it is issued.
    uart_frame_checksum u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_IDLE && block_valid),
        .en    (state == ST_ISSUE && cnt != LAST_IDX),
        .d_in  (d_out),
        .acc   (csum)
    );
`endif

    assign state_dbg = state;

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            d_out       <= 8'h00;
            tx_start    <= 1'b0;
            frame_done  <= 1'b0;
            block_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            d_out       <= d_out_n;
            tx_start    <= tx_start_n;
            frame_done  <= frame_done_n;
            block_ready <= block_ready_n;
            busy        <= busy_n;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        shreg_n       = shreg;
        d_out_n       = d_out;
        tx_start_n    = 1'b0;
        frame_done_n  = 1'b0;
        block_ready_n = 1'b0;
        busy_n        = 1'b1;
        case (state)
            ST_IDLE: begin
                block_ready_n = 1'b1;
                busy_n        = 1'b0;
                if (block_valid) begin
                    state_n       = ST_ISSUE;
                    shreg_n       = block_data;
                    cnt_n         = '0;
                    d_out_n       = HEADER_BYTE;
                    tx_start_n    = 1'b1;
                    block_ready_n = 1'b0;
                    busy_n        = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_flag) begin
                    if (cnt == LAST_IDX) begin
                        state_n      = ST_DONE;
                        frame_done_n = 1'b1;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // cnt already points at the byte about to be issued.
                state_n    = ST_ISSUE;
                tx_start_n = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                if (cnt <= DATA_LAST_IDX) begin
                    d_out_n = shreg[DW-1 -: 8];
                    shreg_n = shreg << 8;
                end else begin
                    d_out_n = csum;
                end
`else
                d_out_n = shreg[DW-1 -: 8];
                shreg_n = shreg << 8;
`endif
            end
            ST_DONE: begin
                state_n       = ST_IDLE;
                block_ready_n = 1'b1;
                busy_n        = 1'b0;
            end
            default: begin
                state_n       = ST_IDLE;
                block_ready_n = 1'b1;
                busy_n        = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Testbench for uart_tx_frame_sequencer (NUM_BYTES=16). Expected frames are
// built from the block data; UART_FRAME_CHECKSUM_EN selects whether a
// trailing checksum byte is expected.
module tb_uart_tx_frame_sequencer;
    import uart_ctrl_pkg::*;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         block_valid = 1'b0;
    logic [W-1:0] block_data = '0;
    logic         tx_done_flag = 1'b0;
    logic         block_ready, tx_start, busy, frame_done;
    logic [7:0]   d_out;
    state_t       state_dbg;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit model_en   = 1'b0;
    bit gap_glitch = 1'b0;

    uart_tx_frame_sequencer #(.NUM_BYTES(NB), .HEADER_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .block_valid  (block_valid),
        .block_data   (block_data),
        .block_ready  (block_ready),
        .tx_done_flag (tx_done_flag),
        .tx_start     (tx_start),
        .d_out        (d_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .state_dbg    (state_dbg)
    );

    // ---------------- UART_tx model ----------------
    // Captures d_out on tx_start, checks it stays stable, pulses tx_done_flag
    // 20 cycles later and checks the next tx_start follows 2 cycles after it.
    initial begin : uart_model
        logic [7:0] cur;
        bit fd;
        bit alive;
        int bad;
        forever begin
            @(negedge clk);
            if (model_en && reset && tx_start) begin
                alive = 1'b1;
                while (alive) begin
                    cur = d_out;
                    got_q.push_back(cur);
                    bad = 0;
                    for (int i = 0; i < 19 && alive; i++) begin
                        @(negedge clk);
                        if (!reset) alive = 1'b0;
                        else if (d_out !== cur) bad++;
                    end
                    if (!alive) break;
                    n_checks++;
                    if (bad != 0)
                        $display("FAIL d_out_stable byte %0d: changed in %0d cycles, required 0", got_q.size(), bad);
                    else
                        n_pass++;
                    tx_done_flag = 1'b1;
                    @(negedge clk);
                    fd = frame_done;
                    if (!reset) begin
                        tx_done_flag = 1'b0;
                        break;
                    end
                    if (gap_glitch) begin
                        @(negedge clk);
                        tx_done_flag = 1'b0;
                    end else begin
                        tx_done_flag = 1'b0;
                        if (!fd) @(negedge clk);
                    end
                    if (fd) break;
                    if (!reset) break;
                    n_checks++;
                    if (tx_start !== 1'b1) begin
                        $display("FAIL done_to_start_spacing: tx_start=%b two cycles after tx_done_flag, required 1", tx_start);
                        break;
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks / scoreboard helpers ----------------
    function automatic void push_frame(input logic [W-1:0] data);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NB; i++) exp_q.push_back(data[W-1-8*i -: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'hA5;
            for (int i = 0; i < NB; i++) x = x ^ data[W-1-8*i -: 8];
            exp_q.push_back(x);
        end
`endif
    endfunction

    // Present a block; returns one cycle after the accepting edge, where the
    // first tx_start must be visible. block_valid is left high.
    task automatic send_block(input logic [W-1:0] data, input string name);
        @(negedge clk);
        block_valid = 1'b1;
        block_data  = data;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || d_out !== 8'hA5 || busy !== 1'b1)
            $display("FAIL %s accept_latency: tx_start=%b d_out=%h busy=%b, required 1 a5 1", name, tx_start, d_out, busy);
        else
            n_pass++;
    endtask

    task automatic wait_frame_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL %s frame_done_timeout: no frame_done in 1000 cycles, required one", name);
        else n_pass++;
    endtask

    task automatic compare_frames(input string name);
        n_checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s frame_length: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        else
            n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL %s byte %0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
            else
                n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (block_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0 || d_out !== 8'h00 ||
            frame_done !== 1'b0 || state_dbg !== ST_IDLE)
            $display("FAIL reset_values: ready=%b busy=%b start=%b d_out=%h done=%b state=%0d, required 1 0 0 00 0 0",
                     block_ready, busy, tx_start, d_out, frame_done, state_dbg);
        else
            n_pass++;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (block_ready !== 1'b1 || tx_start !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL idle_after_reset: %0d bad cycles, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [W-1:0] d;
        d = 128'h00112233445566778899AABBCCDDEEFF;
        model_en = 1'b1;
        exp_q.delete();
        got_q.delete();
        push_frame(d);
        send_block(d, "single");
        block_valid = 1'b0;
        wait_frame_done("single");
        n_checks++;
        if (block_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL single ready_at_done: ready=%b busy=%b, required 0 1", block_ready, busy);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (block_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL single ready_after_done: ready=%b busy=%b done=%b, required 1 0 0", block_ready, busy, frame_done);
        else
            n_pass++;
        repeat (5) @(negedge clk);
        compare_frames("single");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] da, db;
        da = 128'h0123456789ABCDEFFEDCBA9876543210;
        db = 128'hDEADBEEFCAFEF00D13579BDF2468ACE0;
        exp_q.delete();
        got_q.delete();
        push_frame(da);
        push_frame(db);
        send_block(da, "b2b_first");
        block_data = db;
        wait_frame_done("b2b_first");
        n_checks++;
        if (got_q.size() != NB + 1 + ((exp_q.size() == 2*(NB+2)) ? 1 : 0))
            $display("FAIL b2b no_early_accept: %0d bytes at first frame_done, required %0d", got_q.size(), exp_q.size()/2);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (block_ready !== 1'b1) $display("FAIL b2b ready_reopen: ready=%b, required 1", block_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || d_out !== 8'hA5)
            $display("FAIL b2b second_accept: tx_start=%b d_out=%h, required 1 a5", tx_start, d_out);
        else
            n_pass++;
        block_data  = {W{1'b1}};
        block_valid = 1'b0;
        wait_frame_done("b2b_second");
        repeat (5) @(negedge clk);
        compare_frames("b2b");
    endtask

    task automatic test_spurious_done();
        int bad;
        logic [W-1:0] dc;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_done_flag = (i < 3);
            if (tx_start !== 1'b0 || block_ready !== 1'b1 || state_dbg !== ST_IDLE) bad++;
        end
        tx_done_flag = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bad != 0 || state_dbg !== ST_IDLE || tx_start !== 1'b0)
            $display("FAIL spurious_idle: %0d bad cycles state=%0d, required 0 and IDLE", bad, state_dbg);
        else
            n_pass++;
        dc = 128'h8040201008040201F0E1D2C3B4A59687;
        exp_q.delete();
        got_q.delete();
        push_frame(dc);
        gap_glitch = 1'b1;
        send_block(dc, "gap_glitch");
        block_valid = 1'b0;
        wait_frame_done("gap_glitch");
        repeat (40) @(negedge clk);
        gap_glitch = 1'b0;
        compare_frames("gap_glitch");
    endtask

    task automatic test_reset_midframe();
        int starts;
        logic [W-1:0] da, dd;
        da = 128'h11223344556677889900AABBCCDDEEFF;
        dd = 128'h5A5A5A5A0F0F0F0FC3C3C3C312345678;
        send_block(da, "reset_first");
        block_valid = 1'b0;
        starts = 1;
        for (int i = 0; i < 500 && starts < 5; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        n_checks++;
        if (starts != 5) $display("FAIL reset_mid reach_byte5: saw %0d tx_start, required 5", starts);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (block_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0 || d_out !== 8'h00 ||
            frame_done !== 1'b0 || state_dbg !== ST_IDLE)
            $display("FAIL reset_mid outputs: ready=%b busy=%b start=%b d_out=%h done=%b state=%0d, required 1 0 0 00 0 0",
                     block_ready, busy, tx_start, d_out, frame_done, state_dbg);
        else
            n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        got_q.delete();
        push_frame(dd);
        send_block(dd, "reset_restart");
        block_valid = 1'b0;
        wait_frame_done("reset_restart");
        repeat (5) @(negedge clk);
        compare_frames("reset_restart");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_spurious_done();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
